// File: rtl/fp_result_pack_stage.sv
// rtl/fp_result_pack_stage.sv - RNE rounding, IEEE-754 packing and bypass merge; optional FP_PACK_STICKY_FLAGS_EN
module fp_result_pack_stage #(
    parameter int BYPASS_DELAY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        valid_in,
    input  logic        bypass,
    input  logic [31:0] bypass_result,
    input  logic        sign_r,
    input  logic [8:0]  exp_r,
    input  logic [26:0] man_r,
    input  logic        zero_r,
    output logic [31:0] result,
    output logic        result_valid,
    output logic        flag_ovf,
    output logic        flag_unf,
    output logic        flag_inx,
    input  logic        flags_clr
);

    logic [BYPASS_DELAY-1:0] dl_valid_q;
    logic [BYPASS_DELAY-1:0] dl_bypass_q;
    logic [31:0]             dl_word_q [BYPASS_DELAY];

    logic        tail_valid;
    logic        tail_bypass;
    logic [31:0] tail_word;

    logic        round_up;
    logic [24:0] m25;
    logic [9:0]  e10;
    logic [22:0] frac;
    logic [31:0] main_word;
    logic        ev_ovf;
    logic        ev_unf;
    logic        ev_inx;

    logic [31:0] result_q;
    logic        result_valid_q;

    assign tail_valid  = dl_valid_q[BYPASS_DELAY-1];
    assign tail_bypass = dl_bypass_q[BYPASS_DELAY-1];
    assign tail_word   = dl_word_q[BYPASS_DELAY-1];

    // Bypass delay line: aligns special-case verdicts with the main-path operands
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dl_valid_q  <= '0;
            dl_bypass_q <= '0;
            for (int i = 0; i < BYPASS_DELAY; i++) begin
                dl_word_q[i] <= '0;
            end
        end else if (en) begin
            dl_valid_q[0]  <= valid_in;
            dl_bypass_q[0] <= bypass;
            dl_word_q[0]   <= bypass_result;
            for (int i = 1; i < BYPASS_DELAY; i++) begin
                dl_valid_q[i]  <= dl_valid_q[i-1];
                dl_bypass_q[i] <= dl_bypass_q[i-1];
                dl_word_q[i]   <= dl_word_q[i-1];
            end
        end
    end

    // Round to nearest even and pack; exponent widened to 10 bits so 9'h1FF plus carry cannot wrap
    always_comb begin
        round_up  = man_r[2] & (man_r[1] | man_r[0] | man_r[3]);
        m25       = {1'b0, man_r[26:3]} + {24'b0, round_up};
        e10       = {1'b0, exp_r} + {9'b0, m25[24]};
        frac      = m25[24] ? 23'b0 : m25[22:0];
        main_word = {sign_r, e10[7:0], frac};
        ev_ovf    = 1'b0;
        ev_unf    = 1'b0;
        ev_inx    = 1'b0;
        if (zero_r) begin
            main_word = {sign_r, 31'b0};
        end else if (e10 >= 10'd255) begin
            main_word = {sign_r, 8'hFF, 23'b0};
            ev_ovf    = 1'b1;
            ev_inx    = 1'b1;
        end else if (e10 == 10'd0) begin
            main_word = {sign_r, 31'b0};
            ev_unf    = 1'b1;
            ev_inx    = 1'b1;
        end else begin
            ev_inx = man_r[2] | man_r[1] | man_r[0];
        end
    end

    // Output register: loads only when the tail of the line carries an operation
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q       <= '0;
            result_valid_q <= 1'b0;
        end else if (en) begin
            result_valid_q <= tail_valid;
            if (tail_valid) begin
                result_q <= tail_bypass ? tail_word : main_word;
            end
        end
    end

    assign result       = result_q;
    assign result_valid = result_valid_q;

`ifdef FP_PACK_STICKY_FLAGS_EN
    logic flag_ovf_q;
    logic flag_unf_q;
    logic flag_inx_q;
    logic flag_set;

    assign flag_set = tail_valid & ~tail_bypass;

    // Sticky status flags; a clear in the same cycle as a set wins and the set is dropped
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flag_ovf_q <= 1'b0;
            flag_unf_q <= 1'b0;
            flag_inx_q <= 1'b0;
        end else if (en) begin
            if (flags_clr) begin
                flag_ovf_q <= 1'b0;
                flag_unf_q <= 1'b0;
                flag_inx_q <= 1'b0;
            end else if (flag_set) begin
                flag_ovf_q <= flag_ovf_q | ev_ovf;
                flag_unf_q <= flag_unf_q | ev_unf;
                flag_inx_q <= flag_inx_q | ev_inx;
            end
        end
    end

    assign flag_ovf = flag_ovf_q;
    assign flag_unf = flag_unf_q;
    assign flag_inx = flag_inx_q;

    logic unused_bits;
    assign unused_bits = &{1'b0, m25[23]};
`else
    assign flag_ovf = 1'b0;
    assign flag_unf = 1'b0;
    assign flag_inx = 1'b0;

    logic unused_bits;
    assign unused_bits = &{1'b0, flags_clr, ev_ovf, ev_unf, ev_inx, m25[23]};
`endif

endmodule

// File: tb/tb_fp_result_pack_stage.sv
// tb/tb_fp_result_pack_stage.sv - directed self-checking bench for fp_result_pack_stage
module tb_fp_result_pack_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        valid_in;
    logic        bypass;
    logic [31:0] bypass_result;
    logic        sign_r;
    logic [8:0]  exp_r;
    logic [26:0] man_r;
    logic        zero_r;
    logic [31:0] result;
    logic        result_valid;
    logic        flag_ovf;
    logic        flag_unf;
    logic        flag_inx;
    logic        flags_clr;

    int checks   = 0;
    int failures = 0;

`ifdef FP_PACK_STICKY_FLAGS_EN
    localparam bit FLAGS_ON = 1'b1;
`else
    localparam bit FLAGS_ON = 1'b0;
`endif

    fp_result_pack_stage #(.BYPASS_DELAY(2)) dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .valid_in      (valid_in),
        .bypass        (bypass),
        .bypass_result (bypass_result),
        .sign_r        (sign_r),
        .exp_r         (exp_r),
        .man_r         (man_r),
        .zero_r        (zero_r),
        .result        (result),
        .result_valid  (result_valid),
        .flag_ovf      (flag_ovf),
        .flag_unf      (flag_unf),
        .flag_inx      (flag_inx),
        .flags_clr     (flags_clr)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue a non-bypass op and present its main-path operands when it reaches the tail
    task automatic run_main(input logic s, input logic [8:0] e, input logic [26:0] m, input logic z);
        valid_in = 1'b1;
        bypass   = 1'b0;
        step();
        valid_in = 1'b0;
        step();
        sign_r = s;
        exp_r  = e;
        man_r  = m;
        zero_r = z;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        en = 1'b1; valid_in = 1'b0; bypass = 1'b0; bypass_result = '0;
        sign_r = 1'b0; exp_r = '0; man_r = '0; zero_r = 1'b0; flags_clr = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();
        checks++;
        if (result !== 32'h0 || result_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_out: result=%h valid=%b expected 00000000/0", result, result_valid);
        end
        checks++;
        if ({flag_ovf, flag_unf, flag_inx} !== 3'b000) begin
            failures++;
            $display("FAIL reset_flags: flags=%b expected 000", {flag_ovf, flag_unf, flag_inx});
        end
    endtask

    task automatic test_main_path();
        run_main(1'b0, 9'd128, {24'h800000, 3'b000}, 1'b0);
        checks++;
        if (result !== 32'h40000000 || result_valid !== 1'b1) begin
            failures++;
            $display("FAIL main_2p0: result=%h valid=%b expected 40000000/1", result, result_valid);
        end
        step();
        checks++;
        if (result_valid !== 1'b0 || result !== 32'h40000000) begin
            failures++;
            $display("FAIL main_hold: result=%h valid=%b expected 40000000/0", result, result_valid);
        end
        run_main(1'b1, 9'd77, 27'h0, 1'b1);
        checks++;
        if (result !== 32'h80000000) begin
            failures++;
            $display("FAIL zero_neg: result=%h expected 80000000", result);
        end
    endtask

    task automatic test_bypass();
        valid_in = 1'b1; bypass = 1'b1; bypass_result = 32'h7FC00001;
        step();
        valid_in = 1'b0; bypass = 1'b0; bypass_result = 32'h0;
        step();
        checks++;
        if (result_valid !== 1'b0) begin
            failures++;
            $display("FAIL bypass_early: valid=%b expected 0", result_valid);
        end
        sign_r = 1'b0; exp_r = 9'd128; man_r = {24'h800000, 3'b000}; zero_r = 1'b0;
        step();
        checks++;
        if (result !== 32'h7FC00001 || result_valid !== 1'b1) begin
            failures++;
            $display("FAIL bypass_word: result=%h valid=%b expected 7FC00001/1", result, result_valid);
        end
    endtask

    task automatic test_rounding();
        run_main(1'b0, 9'd127, {24'hFFFFFF, 3'b100}, 1'b0);
        checks++;
        if (result !== 32'h40000000) begin
            failures++;
            $display("FAIL round_carry: result=%h expected 40000000", result);
        end
        run_main(1'b0, 9'd127, {24'h800000, 3'b100}, 1'b0);
        checks++;
        if (result !== 32'h3F800000) begin
            failures++;
            $display("FAIL round_tie_even: result=%h expected 3F800000", result);
        end
        run_main(1'b0, 9'd130, {24'hC00001, 3'b110}, 1'b0);
        checks++;
        if (result !== 32'h41400002) begin
            failures++;
            $display("FAIL round_up: result=%h expected 41400002", result);
        end
        run_main(1'b0, 9'd130, {24'hC00001, 3'b011}, 1'b0);
        checks++;
        if (result !== 32'h41400001) begin
            failures++;
            $display("FAIL round_down: result=%h expected 41400001", result);
        end
    endtask

    task automatic test_overflow_ftz();
        run_main(1'b1, 9'd254, {24'hFFFFFF, 3'b111}, 1'b0);
        checks++;
        if (result !== 32'hFF800000) begin
            failures++;
            $display("FAIL ovf_carry: result=%h expected FF800000", result);
        end
        run_main(1'b0, 9'h1FF, {24'hFFFFFF, 3'b100}, 1'b0);
        checks++;
        if (result !== 32'h7F800000) begin
            failures++;
            $display("FAIL ovf_nowrap: result=%h expected 7F800000", result);
        end
        run_main(1'b0, 9'h100, {24'h800000, 3'b000}, 1'b0);
        checks++;
        if (result !== 32'h7F800000) begin
            failures++;
            $display("FAIL ovf_bit8: result=%h expected 7F800000", result);
        end
        run_main(1'b0, 9'd0, {24'h800000, 3'b000}, 1'b0);
        checks++;
        if (result !== 32'h00000000) begin
            failures++;
            $display("FAIL ftz: result=%h expected 00000000", result);
        end
    endtask

    task automatic test_stall();
        logic [31:0] held;
        held = result;
        valid_in = 1'b1; bypass = 1'b1; bypass_result = 32'h12345678;
        step();
        valid_in = 1'b0; bypass = 1'b0; bypass_result = 32'h0;
        step();
        en = 1'b0;
        step();
        step();
        step();
        checks++;
        if (result !== held || result_valid !== 1'b0) begin
            failures++;
            $display("FAIL stall_hold: result=%h valid=%b expected %h/0", result, result_valid, held);
        end
        en = 1'b1;
        step();
        checks++;
        if (result !== 32'h12345678 || result_valid !== 1'b1) begin
            failures++;
            $display("FAIL stall_release: result=%h valid=%b expected 12345678/1", result, result_valid);
        end
        step();
        checks++;
        if (result_valid !== 1'b0) begin
            failures++;
            $display("FAIL stall_once: valid=%b expected 0", result_valid);
        end
    endtask

    task automatic test_reset_midflight();
        int seen;
        seen = 0;
        valid_in = 1'b1; bypass = 1'b1; bypass_result = 32'hDEADBEEF;
        step();
        valid_in = 1'b0; bypass = 1'b0;
        rst = 1'b1;
        #2;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (result_valid !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0 || result !== 32'h0) begin
            failures++;
            $display("FAIL reset_midflight: valid_cycles=%0d result=%h expected 0/00000000", seen, result);
        end
    endtask

    task automatic test_flags();
        logic [2:0] exp_f;
        flags_clr = 1'b1;
        step();
        flags_clr = 1'b0;
        run_main(1'b0, 9'd128, {24'h800000, 3'b000}, 1'b0);
        checks++;
        if ({flag_ovf, flag_unf, flag_inx} !== 3'b000) begin
            failures++;
            $display("FAIL flags_exact: flags=%b expected 000", {flag_ovf, flag_unf, flag_inx});
        end
        run_main(1'b0, 9'd254, {24'hFFFFFF, 3'b111}, 1'b0);
        exp_f = FLAGS_ON ? 3'b101 : 3'b000;
        checks++;
        if ({flag_ovf, flag_unf, flag_inx} !== exp_f) begin
            failures++;
            $display("FAIL flags_ovf: flags=%b expected %b", {flag_ovf, flag_unf, flag_inx}, exp_f);
        end
        run_main(1'b0, 9'd0, {24'h800000, 3'b000}, 1'b0);
        exp_f = FLAGS_ON ? 3'b111 : 3'b000;
        checks++;
        if ({flag_ovf, flag_unf, flag_inx} !== exp_f) begin
            failures++;
            $display("FAIL flags_unf: flags=%b expected %b", {flag_ovf, flag_unf, flag_inx}, exp_f);
        end
        flags_clr = 1'b1;
        step();
        flags_clr = 1'b0;
        checks++;
        if ({flag_ovf, flag_unf, flag_inx} !== 3'b000) begin
            failures++;
            $display("FAIL flags_clear: flags=%b expected 000", {flag_ovf, flag_unf, flag_inx});
        end
        valid_in = 1'b1; bypass = 1'b0;
        step();
        valid_in = 1'b0;
        step();
        sign_r = 1'b0; exp_r = 9'd127; man_r = {24'h800000, 3'b100}; zero_r = 1'b0;
        flags_clr = 1'b1;
        step();
        flags_clr = 1'b0;
        checks++;
        if (flag_inx !== 1'b0 || result !== 32'h3F800000) begin
            failures++;
            $display("FAIL flags_clr_wins: inx=%b result=%h expected 0/3F800000", flag_inx, result);
        end
    endtask

    initial begin
        test_reset();
        test_main_path();
        test_bypass();
        test_rounding();
        test_overflow_ftz();
        test_stall();
        test_reset_midflight();
        test_flags();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
